// File: rtl/alu4b_serial.sv
// Bit-serial 4-bit ALU: add/nand with optional operand and result inversion,
// one result bit per clock, LSB first, behind a valid/ready request/response pair.
module alu4b_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] opCode,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [3:0] out,
    output logic       negative,
    output logic       zero,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] shift_q;
    logic [3:0] shift_next;
    logic [1:0] cnt_q;
    logic       carry_q;
    logic       carry_next;
    logic       bit_a;
    logic       bit_b;
    logic       bit_r;
    logic       accept;
    logic       step;
    logic       finish;

    // Single-bit datapath for the bit currently selected by the counter
    always_comb begin
        bit_a      = a_q[cnt_q] ^ op_q[3];
        bit_b      = b_q[cnt_q] ^ op_q[2];
        bit_r      = '0;
        carry_next = '0;
        if (op_q[1]) begin
            bit_r = ~(bit_a & bit_b);
        end else begin
            bit_r      = bit_a ^ bit_b ^ carry_q;
            carry_next = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
        end
        shift_next = {bit_r ^ op_q[0], shift_q[3:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == 2'd3) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Visible result only updates on completion; the shift register stays internal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            carry_q  <= '0;
            out      <= '0;
            negative <= '0;
            zero     <= '0;
        end else begin
            if (accept) begin
                op_q    <= opCode;
                a_q     <= in1;
                b_q     <= in2;
                cnt_q   <= '0;
                carry_q <= '0;
            end
            if (step) begin
                shift_q <= shift_next;
                carry_q <= carry_next;
                cnt_q   <= cnt_q + 2'd1;
            end
            if (finish) begin
                out      <= shift_next;
                negative <= shift_next[3];
                zero     <= (shift_next == 4'd0);
            end
        end
    end

endmodule
